// File: rtl/phase_timer.sv
`timescale 1ns/1ps
// Phase timer feeding the traffic-light FSM: times each of the four phases in whole
// seconds and presents the remaining time as two BCD digits plus the FSM ctrl bit.
module phase_timer #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int GREEN_SEC   = 20,
  parameter int YELLOW_SEC  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  output logic       ctrl,
  output logic [1:0] phase,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       tick
);

  localparam int            PW          = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_PER_SEC - 1);
  localparam logic [3:0]    GREEN_TENS  = 4'(GREEN_SEC / 10);
  localparam logic [3:0]    GREEN_UNITS = 4'(GREEN_SEC % 10);
  localparam logic [3:0]    YEL_TENS    = 4'(YELLOW_SEC / 10);
  localparam logic [3:0]    YEL_UNITS   = 4'(YELLOW_SEC % 10);

  typedef enum logic [1:0] {
    PH_NS_GREEN = 2'd0,
    PH_YELLOW_A = 2'd1,
    PH_EW_GREEN = 2'd2,
    PH_YELLOW_B = 2'd3
  } phase_e;

  phase_e        r_phase,   w_phase_nxt;
  logic [PW-1:0] r_presc,   w_presc_nxt;
  logic [3:0]    r_tens,    w_tens_nxt;
  logic [3:0]    r_units,   w_units_nxt;
  logic          r_expired, w_expired_nxt;
  logic          r_ctrl,    w_ctrl_nxt;
  logic          r_tick,    w_tick_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase   <= PH_NS_GREEN;
      r_presc   <= '0;
      r_tens    <= GREEN_TENS;
      r_units   <= GREEN_UNITS;
      r_expired <= 1'b0;
      r_ctrl    <= 1'b1;
      r_tick    <= 1'b0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_presc   <= w_presc_nxt;
      r_tens    <= w_tens_nxt;
      r_units   <= w_units_nxt;
      r_expired <= w_expired_nxt;
      r_ctrl    <= w_ctrl_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Expired takes priority over hold so the FSM always sees its advance edge.
  always_comb begin
    w_phase_nxt   = r_phase;
    w_presc_nxt   = r_presc;
    w_tens_nxt    = r_tens;
    w_units_nxt   = r_units;
    w_expired_nxt = r_expired;
    w_ctrl_nxt    = r_ctrl;
    w_tick_nxt    = 1'b0;
    if (r_expired) begin
      w_phase_nxt   = phase_e'(r_phase + 2'd1);
      w_expired_nxt = 1'b0;
      w_presc_nxt   = '0;
      if (w_phase_nxt[0]) begin
        w_tens_nxt  = YEL_TENS;
        w_units_nxt = YEL_UNITS;
        w_ctrl_nxt  = 1'b0;
      end else begin
        w_tens_nxt  = GREEN_TENS;
        w_units_nxt = GREEN_UNITS;
        w_ctrl_nxt  = 1'b1;
      end
    end else if (!hold) begin
      if (r_presc == PRESC_MAX) begin
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b1;
        if (r_units == 4'd0) begin
          w_units_nxt = 4'd9;
          w_tens_nxt  = r_tens - 4'd1;
        end else begin
          w_units_nxt = r_units - 4'd1;
        end
        if (r_tens == 4'd0 && r_units == 4'd1) begin
          w_expired_nxt = 1'b1;
          w_ctrl_nxt    = r_phase[0];
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  assign phase     = r_phase;
  assign ctrl      = r_ctrl;
  assign sec_tens  = r_tens;
  assign sec_units = r_units;
  assign tick      = r_tick;

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Upstream timing stage for the traffic-light controller FSM. It produces the `ctrl` signal that the FSM samples every clock. It tracks the same four-phase sequence as the FSM: NS-green, yellow, EW-green, yellow. It times each phase in whole seconds from a clock prescaler and exports the remaining seconds as two BCD digits for the countdown display.

Parameters:
CLK_PER_SEC, 50000000, clock cycles per one-second tick; legal range >= 2.
GREEN_SEC, 20, duration of each green phase in seconds; legal range 1..99.
YELLOW_SEC, 3, duration of each all-yellow phase in seconds; legal range 1..99.

Ports:
clk  input  1  system clock
rst_n  input  1  reset
hold  input  1  1 = freeze prescaler and countdown; no effect once the phase has expired
ctrl  output  1  registered; drives the FSM ctrl input
phase  output  2  0 = NS green, 1 = yellow, 2 = EW green, 3 = yellow; mirrors the FSM state
sec_tens  output  4  BCD tens digit of seconds remaining
sec_units  output  4  BCD units digit of seconds remaining
tick  output  1  registered one-cycle pulse on each second boundary; debug/display strobe

Behaviour:
- Interface: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - phase = 0, ctrl = 1, tick = 0.
  - {sec_tens, sec_units} = BCD(GREEN_SEC).
  - Prescaler = 0, internal expired flag = 0.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1 while hold = 0 and expired = 0.
  - At count CLK_PER_SEC-1 it wraps to 0 and asserts tick for that one following cycle.
  - Holds its value while hold = 1 or expired = 1.
  - Clears to 0 on every phase advance.
- Countdown, stored directly as two BCD digits (no binary counter):
  - Each tick decrements by 1 with decimal borrow: units 0 -> 9 and tens - 1.
  - When the decrement lands on 00, expired is set on the same edge.
- ctrl encoding, registered, per FSM protocol:
  - Green phase (0, 2): ctrl = 1 while counting; ctrl = 0 once expired.
  - Yellow phase (1, 3): ctrl = 0 while counting; ctrl = 1 once expired.
  - Equivalently, ctrl = phase[0] XNOR expired, and it changes on the same edge as expired.
- Phase advance:
  - Occurs on the first edge with expired = 1, which is exactly the edge where the FSM sees the advancing ctrl value.
  - On that edge: phase <= phase + 1 (wraps 3 -> 0), expired <= 0, prescaler <= 0.
  - Countdown reloads: BCD(YELLOW_SEC) when entering a yellow phase, BCD(GREEN_SEC) when entering a green phase.
  - ctrl <= 1 when entering green, ctrl <= 0 when entering yellow.
- Timing:
  - Phase duration = D*CLK_PER_SEC + 1 cycles, where D is the phase's second count.
  - The display shows 00 for exactly one cycle.
  - Full cycle = 2*(GREEN_SEC + YELLOW_SEC)*CLK_PER_SEC + 4 cycles.
- hold:
  - Asserted mid-second: prescaler and countdown freeze; counting resumes from the frozen value on deassert, with no lost or extra cycle.
  - Asserted while expired = 1: ignored, and the advance still occurs.
- Simultaneous tick and phase advance cannot occur, because the prescaler is frozen while expired.
- Reset mid-operation: all state returns immediately to the reset values. The FSM resets to NS green in lockstep.
- BCD reload constants are computed at elaboration. Out-of-range parameters are a configuration error and need not be handled.

Test Plan:
1. CLK_PER_SEC=4, GREEN_SEC=5, YELLOW_SEC=3; release reset -> phase=0, ctrl=1, display 05. Display steps 04, 03, 02, 01 at cycles 4, 8, 12, 16. At cycle 20: display 00 and ctrl=0. At cycle 21: phase=1, display 03, ctrl=0.
2. Continue from scenario 1 -> ctrl rises to 1 at cycle 33 with display 00. At cycle 34: phase=2, display 05, ctrl=1. Phase wraps 3 -> 0 at cycle 68, and tick pulses every 4 counting cycles.
3. GREEN_SEC=12, CLK_PER_SEC=2 -> display sequence 12, 11, 10, 09, 08 (borrow across the tens digit). No non-BCD value (nibble > 9) ever appears.
4. Assert hold for 7 cycles at prescaler count 2 of second "04" -> display stays 04 and tick stays 0 during hold. After release, the next decrement is exactly 2 cycles later.
5. Assert hold on the cycle where ctrl=0 in phase 0 -> phase still advances to 1 on the next edge with display 03.
6. Pulse rst_n low asynchronously mid-phase 2 with display 02 -> outputs return to phase=0, ctrl=1, display 05 without waiting for a clock edge. Counting restarts cleanly after release.
